// File: rtl/seq_mac_pkg.sv
// Shared constants for the sequential multiply-accumulate unit.
// State encoding and default datapath width.
package seq_mac_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        MAC_IDLE = 2'b00,
        MAC_RUN  = 2'b01,
        MAC_DONE = 2'b10
    } mac_state_t;

endpackage

// File: rtl/seq_mac.sv
// Shift-add multiply-accumulate: result = op_A * op_B + addend (unsigned).
// Fixed WIDTH-cycle iteration with a start/busy/done handshake.
module seq_mac
    import seq_mac_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [WIDTH-1:0] op_A,
    input  logic [WIDTH-1:0] op_B,
    input  logic [WIDTH-1:0] addend,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             busy,
    output logic             done,
    output logic             mac_sign_flag
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mac_state_t state;
    mac_state_t next_state;

    logic [RW-1:0]    mcand;
    logic [RW-1:0]    acc;
    logic [RW-1:0]    acc_sum;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;
    logic             accept;
    logic             last;

    assign acc_sum = mplier[0] ? (acc + mcand) : acc;

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        last       = 1'b0;
        unique case (state)
            MAC_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = MAC_RUN;
                end
            end
            MAC_RUN: begin
                if (count == LAST) begin
                    last       = 1'b1;
                    next_state = MAC_DONE;
                end
            end
            MAC_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = MAC_RUN;
                end else begin
                    next_state = MAC_IDLE;
                end
            end
            default: next_state = MAC_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= MAC_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DONE lasts exactly one cycle, so done can be decoded from state.
    assign busy = (state == MAC_RUN);
    assign done = (state == MAC_DONE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mcand         <= '0;
            mplier        <= '0;
            acc           <= '0;
            count         <= '0;
            result_hi     <= '0;
            result_lo     <= '0;
            mac_sign_flag <= 1'b0;
        end else if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, op_A};
            mplier <= op_B;
            acc    <= {{WIDTH{1'b0}}, addend};
            count  <= '0;
        end else if (state == MAC_RUN) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (last) begin
                result_hi     <= acc_sum[RW-1:WIDTH];
                result_lo     <= acc_sum[WIDTH-1:0];
                mac_sign_flag <= acc_sum[RW-1];
            end
        end
    end

endmodule

// File: tb/tb_seq_mac.sv
// Scoreboard bench for seq_mac: driver queues expected results,
// a monitor pops and checks them whenever done is presented.
module tb_seq_mac;

    logic       CLK;
    logic       RST_N;
    logic       start;
    logic [7:0] op_A;
    logic [7:0] op_B;
    logic [7:0] addend;
    logic [7:0] result_hi;
    logic [7:0] result_lo;
    logic       busy;
    logic       done;
    logic       mac_sign_flag;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          at;
        logic [15:0] res;
    } exp_t;

    exp_t sbq[$];

    seq_mac #(.WIDTH(8)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .start(start),
        .op_A(op_A),
        .op_B(op_B),
        .addend(addend),
        .result_hi(result_hi),
        .result_lo(result_lo),
        .busy(busy),
        .done(done),
        .mac_sign_flag(mac_sign_flag)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done sample must match the oldest queued result.
    always @(negedge CLK) begin
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none",
                         cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("result", {16'h0, result_hi, result_lo}, {16'h0, e.res});
                chk("sign_flag", {31'h0, mac_sign_flag}, {31'h0, e.res[15]});
                chk("done_cycle", cyc, e.at);
                chk("busy_at_done", {31'h0, busy}, 32'h0);
            end
        end
    end

    function automatic logic [15:0] mac(input logic [7:0] a, b, c);
        return 16'(a) * 16'(b) + 16'(c);
    endfunction

    task automatic issue(input logic [7:0] a, b, c, input bit push);
        @(negedge CLK);
        op_A   = a;
        op_B   = b;
        addend = c;
        start  = 1'b1;
        if (push) sbq.push_back('{cyc + 9, mac(a, b, c)});
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d pending results expected 0",
                     sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        RST_N  = 1'b0;
        start  = 1'b0;
        op_A   = 8'h00;
        op_B   = 8'h00;
        addend = 8'h00;
        #2;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_hi", {24'h0, result_hi}, 32'h0);
        chk("rst_lo", {24'h0, result_lo}, 32'h0);
        chk("rst_sign", {31'h0, mac_sign_flag}, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;

        issue(8'h0C, 8'h05, 8'h03, 1'b1);
        wait_empty();
        issue(8'hFF, 8'hFF, 8'hFF, 1'b1);
        wait_empty();
        issue(8'h0E, 8'h07, 8'h02, 1'b1);
        wait_empty();
        issue(8'h00, 8'h9A, 8'h07, 1'b1);
        wait_empty();

        // Start during RUN must be ignored.
        issue(8'h03, 8'h04, 8'h01, 1'b1);
        @(negedge CLK);
        @(negedge CLK);
        op_A   = 8'h55;
        op_B   = 8'h66;
        addend = 8'h77;
        start  = 1'b1;
        @(negedge CLK);
        chk("busy_run", {31'h0, busy}, 32'h1);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("busy_run", {31'h0, busy}, 32'h1);
        end
        wait_empty();
        @(negedge CLK);
        chk("hold_lo", {24'h0, result_lo}, 32'h0D);
        chk("hold_done", {31'h0, done}, 32'h0);
        chk("hold_busy", {31'h0, busy}, 32'h0);

        // Asynchronous abort mid-run.
        issue(8'hAA, 8'hBB, 8'hCC, 1'b0);
        repeat (3) @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_hi", {24'h0, result_hi}, 32'h0);
        chk("abort_lo", {24'h0, result_lo}, 32'h0);
        chk("abort_sign", {31'h0, mac_sign_flag}, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        issue(8'h11, 8'h11, 8'h00, 1'b1);
        wait_empty();

        // Back-to-back with start held high.
        @(negedge CLK);
        op_A   = 8'h12;
        op_B   = 8'h34;
        addend = 8'h56;
        start  = 1'b1;
        sbq.push_back('{cyc + 9, mac(8'h12, 8'h34, 8'h56)});
        @(negedge CLK);
        op_A   = 8'hA5;
        op_B   = 8'h02;
        addend = 8'h10;
        sbq.push_back('{cyc + 17, mac(8'hA5, 8'h02, 8'h10)});
        repeat (9) @(negedge CLK);
        op_A   = 8'h80;
        op_B   = 8'h80;
        addend = 8'h80;
        sbq.push_back('{cyc + 17, mac(8'h80, 8'h80, 8'h80)});
        repeat (9) @(negedge CLK);
        start = 1'b0;
        wait_empty();
        repeat (3) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_mac.md
Name: seq_mac

Overview:
- Multi-cycle shift-add multiply-accumulate unit. Computes result = op_A * op_B + addend, unsigned, over a 2*WIDTH-bit result.
- It is the inverse of the datapath's repeated-subtraction divide. Feeding it a quotient, the divisor and the remainder reconstructs the dividend.
- Sits beside the ALU in the ASIP datapath. Uses a start/busy/done handshake so the controller can sequence MAX/MIN/AVG checks and scaling.

Parameters:
- WIDTH, 8, operand width in bits. Result width is 2*WIDTH.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  request. Sampled only when state is IDLE or DONE.
- op_A  in  WIDTH  multiplicand, unsigned.
- op_B  in  WIDTH  multiplier, unsigned.
- addend  in  WIDTH  accumulate term, unsigned, zero-extended.
- result_hi  out  WIDTH  upper half of the result (registered).
- result_lo  out  WIDTH  lower half of the result (registered).
- busy  out  1  high while the operation is iterating.
- done  out  1  single-cycle completion pulse.
- mac_sign_flag  out  1  equals result_hi[WIDTH-1], updated together with the result.

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE; result_hi, result_lo, busy, done, mac_sign_flag all 0; internal accumulator, shift registers and counter all 0.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at an edge:
  - latch mcand = zero-extended op_A (2*WIDTH bits);
  - latch mplier = op_B;
  - acc = zero-extended addend;
  - count = 0;
  - go to RUN; busy=1.
- DONE with start=0: go to IDLE. done deasserts.
- RUN, each edge:
  - if mplier[0], acc = acc + mcand (2*WIDTH-bit add, cannot overflow because max is (2^W-1)^2 + 2^W-1 < 2^(2W));
  - mcand <<= 1; mplier >>= 1; count++.
- On the WIDTH-th RUN edge:
  - the final iteration result is written to {result_hi, result_lo};
  - mac_sign_flag updates; done=1; busy=0; state goes to DONE.
- Latency: start sampled at edge E0 gives done=1 in the cycle after edge E0+WIDTH, i.e. 9 edges for WIDTH=8.
- Latency is fixed. There is no early exit on a zero multiplier.
- done is high for exactly one cycle, unless start is accepted in DONE. In that case done still drops at the next edge and busy rises.
- start while in RUN is ignored. Operands are latched only at acceptance, so input changes during RUN have no effect.
- Outputs hold their last result until the next completion or reset. They are not cleared at start.
- Reset asserted mid-RUN aborts the operation immediately. Outputs go to their reset values and no done is issued.
- Back-to-back: start held high continuously yields one result every WIDTH+1 cycles.

Decomposition:
- Shared package holds:
  - the state encoding constants MAC_IDLE=2'b00, MAC_RUN=2'b01, MAC_DONE=2'b10;
  - the default width constant DATA_W=8, shared with the ALU operand width.
- No sub-module. The FSM, shift registers and adder fit in one module.

Test Plan:
- Reset, then start with op_A=0x0C, op_B=0x05, addend=0x03 → after 9 edges done=1 for one cycle, result_hi=0x00, result_lo=0x3F, mac_sign_flag=0.
- Maximum operands op_A=0xFF, op_B=0xFF, addend=0xFF → result 0xFF00, mac_sign_flag=1, no wrap.
- Divide inverse: op_A=0x0E (q=14), op_B=0x07, addend=0x02 (r=2) → result 0x0064 (100). Also op_A=0x00, op_B=0x9A, addend=0x07 → 0x0007.
- start pulsed again 3 cycles into RUN with different operands → ignored. The first result appears unchanged at the original done time and busy stays high until then.
- RST_N driven low at RUN cycle 4 → busy, done and all results are 0 asynchronously. After release, a new start completes normally with the correct result.
- start held high for 3 operations with operands changing at each acceptance → done pulses spaced exactly 9 cycles apart, each result matching its latched operands.
